// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// Address is held stable by the master for as long as req is high.
interface ifu_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/ifu_fetch.sv
// Fetch / next-PC stage: fetches one word per request into IR, and on update computes the next PC with a one-cycle PC write strobe.
// Fetch: req from the cycle after fetch_en, IR valid the cycle after ack; memory stalls are absorbed by waiting in REQ indefinitely.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pc_in_i,
  input  logic         fetch_en_i,
  input  logic         upd_en_i,
  input  logic [1:0]   npc_sel_i,
  input  logic         branch_taken_i,
  input  logic [31:0]  rs_data_i,
  ifu_fetch_if.master  imem,
  output logic [31:0]  ir_o,
  output logic         ir_valid_o,
  output logic         fetch_err_o,
  output logic [31:0]  pc_next_o,
  output logic         pc_wr_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] pc_next_q, pc_next_d;
  logic [31:0] addr_q, addr_d;
  logic        pc_wr_q, pc_wr_d;
  logic        fetch_err_q, fetch_err_d;

  logic [31:0] br_off;
  logic [31:0] npc;

  // Branch displacement is in words relative to the instruction after the branch.
  assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  always_comb begin
    npc = pc4_q;
    case (npc_sel_i)
      2'b00:   npc = pc4_q;
      2'b01:   npc = branch_taken_i ? (pc4_q + br_off) : pc4_q;
      2'b10:   npc = {pc4_q[31:28], ir_q[25:0], 2'b00};
      default: npc = rs_data_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    pc4_d       = pc4_q;
    pc_next_d   = pc_next_q;
    addr_d      = addr_q;
    pc_wr_d     = 1'b0;
    fetch_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        // An update request takes priority and drops a concurrent fetch.
        if (upd_en_i) begin
          pc_next_d = npc;
          pc_wr_d   = 1'b1;
        end else if (fetch_en_i) begin
          if (pc_in_i[1:0] == 2'b00) begin
            addr_d  = pc_in_i;
            state_d = REQ;
          end else begin
            fetch_err_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          pc4_d   = addr_q + 32'd4;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ir_q        <= 32'd0;
      pc4_q       <= RESET_PC + 32'd4;
      pc_next_q   <= RESET_PC;
      addr_q      <= RESET_PC;
      pc_wr_q     <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      pc4_q       <= pc4_d;
      pc_next_q   <= pc_next_d;
      addr_q      <= addr_d;
      pc_wr_q     <= pc_wr_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign imem.imem_req  = (state_q == REQ);
  assign imem.imem_addr = addr_q;
  assign ir_o           = ir_q;
  assign ir_valid_o     = (state_q == DONE);
  assign fetch_err_o    = fetch_err_q;
  assign pc_next_o      = pc_next_q;
  assign pc_wr_o        = pc_wr_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: transaction-level model compared every cycle, plus literal expectations.
`timescale 1ns/1ps
module tb_ifu_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        fetch_en, upd_en;
  logic [1:0]  npc_sel;
  logic        branch_taken;
  logic [31:0] rs_data;
  logic [31:0] ir, pc_next;
  logic        ir_valid, fetch_err, pc_wr, busy;

  ifu_fetch_if imem ();

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in_i        (pc_in),
    .fetch_en_i     (fetch_en),
    .upd_en_i       (upd_en),
    .npc_sel_i      (npc_sel),
    .branch_taken_i (branch_taken),
    .rs_data_i      (rs_data),
    .imem           (imem.master),
    .ir_o           (ir),
    .ir_valid_o     (ir_valid),
    .fetch_err_o    (fetch_err),
    .pc_next_o      (pc_next),
    .pc_wr_o        (pc_wr),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: is a fetch outstanding, has a word just been delivered.
  bit          m_waiting, m_got, m_wr, m_err;
  logic [31:0] m_addr, m_ir, m_pc4, m_pcn;
  bit          chk_on = 1'b0;

  function automatic logic [31:0] model_npc();
    logic signed [15:0] imm;
    int                 off;
    imm = m_ir[15:0];
    off = int'(imm) * 4;
    case (npc_sel)
      2'b00:   return m_pc4;
      2'b01:   return branch_taken ? m_pc4 + 32'(off) : m_pc4;
      2'b10:   return (m_pc4 & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) << 2);
      default: return rs_data;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_waiting = 0; m_got = 0; m_wr = 0; m_err = 0;
      m_addr = RESET_PC; m_ir = 0; m_pc4 = RESET_PC + 4; m_pcn = RESET_PC;
    end else begin
      m_wr = 0; m_err = 0;
      if (m_got) begin
        m_got = 0;
      end else if (m_waiting) begin
        if (imem.imem_ack) begin
          m_ir = imem.imem_rdata; m_pc4 = m_addr + 4; m_waiting = 0; m_got = 1;
        end
      end else if (upd_en) begin
        m_pcn = model_npc(); m_wr = 1;
      end else if (fetch_en) begin
        if (pc_in % 4 == 0) begin m_addr = pc_in; m_waiting = 1; end
        else m_err = 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      chk("imem_req",  32'(imem.imem_req), 32'(m_waiting));
      chk("imem_addr", imem.imem_addr, m_addr);
      chk("ir",        ir, m_ir);
      chk("ir_valid",  32'(ir_valid), 32'(m_got));
      chk("fetch_err", 32'(fetch_err), 32'(m_err));
      chk("pc_next",   pc_next, m_pcn);
      chk("pc_wr",     32'(pc_wr), 32'(m_wr));
      chk("busy",      32'(busy), 32'(m_waiting | m_got));
    end
  end

  int nb, nv, ne, nr;
  bit addr_ok;

  task automatic do_fetch(input logic [31:0] a, input int waits, input logic [31:0] d);
    @(negedge clk);
    pc_in = a; fetch_en = 1'b1;
    nb = 0; nv = 0; ne = 0; nr = 0; addr_ok = 1'b1;
    for (int i = 0; i < waits + 4; i++) begin
      @(negedge clk);
      fetch_en = 1'b0;
      nb += int'(busy); nv += int'(ir_valid); ne += int'(fetch_err); nr += int'(imem.imem_req);
      if (imem.imem_req && imem.imem_addr !== a) addr_ok = 1'b0;
      imem.imem_ack   = (i == waits);
      imem.imem_rdata = (i == waits) ? d : 32'hDEAD_BEEF;
    end
    imem.imem_ack = 1'b0;
  endtask

  task automatic do_upd(input logic [1:0] sel, input logic tk, input logic [31:0] rs,
                        input logic [31:0] exp, input string name);
    @(negedge clk);
    upd_en = 1'b1; npc_sel = sel; branch_taken = tk; rs_data = rs;
    @(negedge clk);
    upd_en = 1'b0;
    chk({name, "_pc_next"}, pc_next, exp);
    chk({name, "_pc_wr"}, 32'(pc_wr), 32'd1);
    @(negedge clk);
    chk({name, "_pc_wr_end"}, 32'(pc_wr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; pc_in = RESET_PC; fetch_en = 0; upd_en = 0; npc_sel = 0;
    branch_taken = 0; rs_data = 0; imem.imem_ack = 0; imem.imem_rdata = 0;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc_next", pc_next, 32'h0000_3000);
    chk("rst_pc_wr", 32'(pc_wr), 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(imem.imem_req), 32'd0);

    do_fetch(32'h0000_3000, 3, 32'h8C01_0004);
    chk("f3_busy_cycles", 32'(nb), 32'd5);
    chk("f3_valid_pulses", 32'(nv), 32'd1);
    chk("f3_addr_stable", 32'(addr_ok), 32'd1);
    chk("f3_ir", ir, 32'h8C01_0004);

    do_fetch(32'h0000_3004, 0, 32'h1000_FFFF);
    chk("f0_busy_cycles", 32'(nb), 32'd2);
    do_upd(2'b01, 1'b1, 32'd0, 32'h0000_3004, "br_taken");
    do_upd(2'b01, 1'b0, 32'd0, 32'h0000_3008, "br_not");

    do_fetch(32'h0000_3008, 1, 32'h0C00_0C10);
    do_upd(2'b10, 1'b0, 32'd0, 32'h0000_3040, "jump");
    do_upd(2'b11, 1'b0, 32'h0000_301C, 32'h0000_301C, "jr");

    do_fetch(32'h0000_3002, 0, 32'h1234_5678);
    chk("mis_err_pulses", 32'(ne), 32'd1);
    chk("mis_req", 32'(nr), 32'd0);
    chk("mis_busy", 32'(nb), 32'd0);
    chk("mis_ir", ir, 32'h0C00_0C10);

    do_fetch(32'hFFFF_FFFC, 0, 32'h0000_0000);
    do_upd(2'b00, 1'b0, 32'd0, 32'h0000_0000, "wrap");

    @(negedge clk);
    pc_in = 32'h0000_3010; fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    chk("mid_req_before", 32'(imem.imem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_req_after", 32'(imem.imem_req), 32'd0);
    chk("mid_ir", ir, 32'd0);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    imem.imem_ack = 1'b0;
    chk("late_ack_valid", 32'(ir_valid), 32'd0);
    chk("late_ack_ir", ir, 32'd0);
    chk("late_ack_busy", 32'(busy), 32'd0);

    @(negedge clk);
    pc_in = 32'h0000_3000; fetch_en = 1'b1; upd_en = 1'b1; npc_sel = 2'b00;
    @(negedge clk);
    fetch_en = 1'b0; upd_en = 1'b0;
    chk("both_pc_wr", 32'(pc_wr), 32'd1);
    chk("both_pc_next", pc_next, 32'h0000_3004);
    chk("both_req", 32'(imem.imem_req), 32'd0);
    @(negedge clk);
    chk("both_req_later", 32'(imem.imem_req), 32'd0);
    chk("both_busy", 32'(busy), 32'd0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch and next-PC stage of the multicycle datapath. It sits between the program counter register and instruction memory. On a controller request it fetches the word at the current PC over a request/acknowledge handshake and latches it into the instruction register. On a separate controller request it computes the next PC (sequential, branch, jump, register jump) and issues the one-cycle write strobe that drives the PC register's `din`/`control` inputs.

## Interface
- `RESET_PC`, 32'h3000, reset address; must match the PC register's reset value
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `pc_in`  in  32  current PC, from the PC register `dout`
- `fetch_en`  in  1  controller request to fetch one instruction; sampled in IDLE only
- `upd_en`  in  1  controller request to update the PC; sampled in IDLE only
- `npc_sel`  in  2  next-PC source: 00 PC+4, 01 branch, 10 jump, 11 register
- `branch_taken`  in  1  branch condition from the ALU; used when `npc_sel`=01
- `rs_data`  in  32  register target for `npc_sel`=11
- `imem_req`  out  1  instruction memory request; held high until ack
- `imem_addr`  out  32  word address of the request; stable while `imem_req`=1
- `imem_ack`  in  1  memory acknowledge; `imem_rdata` valid in the same cycle
- `imem_rdata`  in  32  instruction word
- `ir`  out  32  instruction register
- `ir_valid`  out  1  one-cycle pulse when `ir` has been loaded
- `fetch_err`  out  1  one-cycle pulse on a misaligned fetch
- `pc_next`  out  32  registered next-PC value, to PC register `din`
- `pc_wr`  out  1  one-cycle PC write strobe, to PC register `control`
- `busy`  out  1  high in any state other than IDLE

## Operation
- **FSM states:** IDLE, REQ, DONE.
- **IDLE, `upd_en`=1:**
  - Register `pc_next` from the selected source.
  - Set `pc_wr`=1 for the next cycle only.
  - Remain in IDLE.
- **IDLE, `fetch_en`=1, `upd_en`=0, `pc_in[1:0]`=0:**
  - Latch `imem_addr`=`pc_in`.
  - Go to REQ.
- **IDLE, `fetch_en`=1, `upd_en`=0, `pc_in[1:0]`≠0:**
  - Pulse `fetch_err` next cycle.
  - Issue no request; leave `ir` unchanged.
  - Remain in IDLE.
- **Simultaneous `fetch_en` and `upd_en` in IDLE:** the update wins and `fetch_en` is dropped. The controller must not assert both.
- **REQ:**
  - `imem_req`=1.
  - Wait indefinitely for `imem_ack`.
  - On ack: `ir` ← `imem_rdata`, `pc4` ← `imem_addr`+4, go to DONE.
- **DONE:**
  - `ir_valid`=1 for exactly this cycle.
  - Return to IDLE.
- **`fetch_en`/`upd_en` outside IDLE:** ignored, not queued.
- **`pc4` (internal):** address of the latched instruction plus 4, modulo 2^32. 32'hFFFFFFFC+4 wraps to 0.
- **Next-PC sources:**
  - 00: `pc4`.
  - 01: if `branch_taken`, `pc4` + (sign-extended `ir[15:0]` << 2), modulo 2^32; otherwise `pc4`.
  - 10: {`pc4[31:28]`, `ir[25:0]`, 2'b00}.
  - 11: `rs_data`, unmodified; no alignment check on update.
- **`imem_ack` outside REQ:** ignored.

## Timing
- **Reset:**
  - State IDLE.
  - `ir`=0, `pc4`=`RESET_PC`+4, `pc_next`=`RESET_PC`, `imem_addr`=`RESET_PC`.
  - `imem_req`=0, `ir_valid`=0, `fetch_err`=0, `pc_wr`=0, `busy`=0.
- **Fetch latency:** `fetch_en` at edge N → `imem_req` high from cycle N+1. An ack sampled at edge M → `ir`/`ir_valid` visible in cycle M+1, back in IDLE at M+2.
  - Zero-wait memory (ack in the first REQ cycle): `ir_valid` two cycles after `fetch_en`.
- **Update latency:** `upd_en` at edge N → `pc_next`/`pc_wr` valid during cycle N+1. The PC register loads at edge N+2.
- **`busy`:** high in REQ and DONE.
- **Reset mid-REQ:** `imem_req` drops the cycle after reset and `ir` clears. A late ack arriving afterwards is ignored.
- **Back-to-back fetches:** a new `fetch_en` is accepted at the earliest in the IDLE cycle after DONE.

## Test plan
- **Reset, then idle:** reset; hold `fetch_en`=`upd_en`=0 → `pc_next`=32'h3000, `pc_wr`=0, `ir`=0, `busy`=0.
- **Fetch with 3 wait cycles:** `pc_in`=32'h3000, `fetch_en` pulse, ack after 3 REQ cycles with `imem_rdata`=32'h8C010004 → `imem_addr`=32'h3000 held stable throughout; `ir`=32'h8C010004; one `ir_valid` pulse; `busy` high for 5 cycles.
- **Branch, taken and not taken:** `ir`=32'h1000FFFF fetched from 32'h3004:
  - `npc_sel`=01, `branch_taken`=1 → `pc_next`=32'h3004, `pc_wr` pulse.
  - `branch_taken`=0 → `pc_next`=32'h3008.
- **Jump and register jump:** `ir`=32'h0C000C10 at 32'h3008:
  - `npc_sel`=10 → `pc_next`=32'h00003040.
  - `npc_sel`=11 with `rs_data`=32'h0000301C → `pc_next`=32'h301C.
- **Misaligned fetch and wrap:**
  - `pc_in`=32'h3002, `fetch_en` → `fetch_err` pulse, no `imem_req`, `ir` unchanged.
  - Fetch at 32'hFFFFFFFC, then `npc_sel`=00 → `pc_next`=0.
- **Reset mid-REQ, simultaneous requests:**
  - Assert `rst` during REQ, then ack → `imem_req` low, `ir`=0, no `ir_valid`.
  - `fetch_en`+`upd_en` together in IDLE → only `pc_wr` pulses, no request.
